serial_subtractor: RTL and testbench

- Bit-serial WIDTH-bit subtractor, the inverse arithmetic path of the team's adder blocks. Computes diff = a - b with borrow-out.
- Processes one bit per clock, LSB first, through a single full-subtractor stage built from two half subtractors.
- Used where area matters more than latency.
- Operands are captured on a start request; results are reported with a one-cycle done pulse.

---
 rtl/serial_subtractor_pkg.sv | 16 +
 rtl/serial_subtractor_if.sv | 31 +++
 rtl/half_subtractor.sv | 19 +
 rtl/serial_subtractor.sv | 134 +++++++++++++
 tb/tb_serial_subtractor.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// ----------------------------------------------------------------------------
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor: FSM state encoding and
//   the default operand width.
// ----------------------------------------------------------------------------
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sub_state_e;

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_if.sv
// ----------------------------------------------------------------------------
// serial_subtractor_if
//   Request/result bundle for serial_subtractor.
//   master : drives start, a, b; observes busy, done, diff, bout
//   slave  : the subtractor side
// ----------------------------------------------------------------------------
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout
    );

endinterface : serial_subtractor_if

// File: rtl/half_subtractor.sv
// ----------------------------------------------------------------------------
// half_subtractor
//   One-bit half subtractor: computes x - y.
//   x_i  : minuend bit
//   y_i  : subtrahend bit
//   d_o  : difference bit (x ^ y)
//   bo_o : borrow out (~x & y)
// ----------------------------------------------------------------------------
module half_subtractor (
    input  logic x_i,
    input  logic y_i,
    output logic d_o,
    output logic bo_o
);

    assign d_o  = x_i ^ y_i;
    assign bo_o = ~x_i & y_i;

endmodule : half_subtractor

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor, diff = a - b (mod 2^WIDTH) with borrow-out.
//   One bit per clock, LSB first, through a full-subtractor stage made of two
//   half subtractors.
//
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of serial_subtractor_if
//         start/a/b in; busy/done/diff/bout out
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; operands captured on the accepting edge
//   SHIFT | one bit processed per edge, WIDTH edges in total
//   DONE  | done pulse; diff/bout already hold the new result
// ----------------------------------------------------------------------------
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    serial_subtractor_if.slave bus
);

    localparam int              CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sub_state_e       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             hs1_d, hs1_bo;
    logic             bit_d, hs2_bo;
    logic             borrow_nxt;
    logic [WIDTH-1:0] res_shift;

    // Full subtractor: first stage handles a - b, second subtracts the
    // incoming borrow from that partial difference.
    half_subtractor u_hs1 (
        .x_i  (sa_q[0]),
        .y_i  (sb_q[0]),
        .d_o  (hs1_d),
        .bo_o (hs1_bo)
    );

    half_subtractor u_hs2 (
        .x_i  (hs1_d),
        .y_i  (borrow_q),
        .d_o  (bit_d),
        .bo_o (hs2_bo)
    );

    assign borrow_nxt = hs1_bo | hs2_bo;
    assign res_shift  = {bit_d, res_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    sa_d     = bus.a;
                    sb_d     = bus.b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sa_d     = sa_q >> 1;
                sb_d     = sb_q >> 1;
                res_d    = res_shift;
                borrow_d = borrow_nxt;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // Publish straight from the shift path so diff/bout are
                    // valid in the DONE cycle and stay put during later SHIFTs.
                    diff_d  = res_shift;
                    bout_d  = borrow_nxt;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign bus.done = (state_q == ST_DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;
    int   done_cnt8 = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8))  bus8 ();
    serial_subtractor_if #(.WIDTH(16)) bus16 ();

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    serial_subtractor #(.WIDTH(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    logic hs_x, hs_y, hs_d, hs_bo;
    half_subtractor u_hs (
        .x_i  (hs_x),
        .y_i  (hs_y),
        .d_o  (hs_d),
        .bo_o (hs_bo)
    );

    always @(negedge clk) if (bus8.done === 1'b1) done_cnt8++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start an 8-bit op and wait for done. lat = edges from accepting edge
    // to the edge that raised done; bcyc = busy cycles seen over that span.
    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       output logic [8:0] res, output int lat, output int bcyc);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        bus8.a     = ~a;
        bus8.b     = a ^ b;
        lat  = 0;
        bcyc = 0;
        while (bus8.done !== 1'b1 && lat < 40) begin
            if (bus8.busy === 1'b1) bcyc++;
            @(posedge clk); #1;
            lat++;
        end
        if (bus8.busy === 1'b1) bcyc++;
        if (lat >= 40) chk("op8_timeout", 64'(lat), 64'd8);
        res = {bus8.bout, bus8.diff};
        @(posedge clk); #1;
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, output logic [16:0] res);
        int lat;
        @(negedge clk);
        bus16.start = 1'b1;
        bus16.a     = a;
        bus16.b     = b;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        bus16.a     = b;
        bus16.b     = a;
        lat = 0;
        while (bus16.done !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 60) chk("op16_timeout", 64'(lat), 64'd16);
        res = {bus16.bout, bus16.diff};
        @(posedge clk); #1;
    endtask

    initial begin
        logic [8:0]  r8;
        logic [16:0] r16;
        logic [1:0]  hs_tab [4];
        logic [7:0]  ra, rb;
        logic [15:0] wa, wb;
        int lat, bcyc, dc0, cyc, ndone, unstable;
        int t [3];

        bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;
        bus16.start = 1'b0; bus16.a = '0; bus16.b = '0;
        hs_x = 1'b0; hs_y = 1'b0;

        // half subtractor truth table, index {x,y}, entry {bo,d}
        hs_tab[0] = 2'b00; hs_tab[1] = 2'b11; hs_tab[2] = 2'b01; hs_tab[3] = 2'b00;
        for (int i = 0; i < 4; i++) begin
            {hs_x, hs_y} = 2'(i);
            #1;
            chk($sformatf("hs_%0d", i), 64'({hs_bo, hs_d}), 64'(hs_tab[i]));
        end

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy",  64'(bus8.busy), 64'd0);
        chk("rst_done",  64'(bus8.done), 64'd0);
        chk("rst_diff",  64'(bus8.diff), 64'd0);
        chk("rst_bout",  64'(bus8.bout), 64'd0);
        chk("rst_busy16", 64'(bus16.busy), 64'd0);

        // 5 - 3
        op8(8'h05, 8'h03, r8, lat, bcyc);
        chk("lat_cycles", 64'(lat + 1), 64'd9);
        chk("busy_cycles", 64'(bcyc), 64'd9);
        chk("r_05_03", 64'(r8), 64'h002);
        chk("done_pulse", 64'(bus8.done), 64'd0);
        chk("busy_after", 64'(bus8.busy), 64'd0);
        chk("diff_held", 64'(bus8.diff), 64'h02);

        op8(8'h03, 8'h05, r8, lat, bcyc);
        chk("r_03_05", 64'(r8), 64'h1FE);
        op8(8'h00, 8'hFF, r8, lat, bcyc);
        chk("r_00_FF", 64'(r8), 64'h101);
        op8(8'hFF, 8'hFF, r8, lat, bcyc);
        chk("r_FF_FF", 64'(r8), 64'h000);

        // start during SHIFT is ignored
        dc0 = done_cnt8;
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h80; bus8.b = 8'h01;
        @(negedge clk);
        bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00;
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h33;
        @(negedge clk);
        bus8.start = 1'b0; bus8.a = 8'h11; bus8.b = 8'h77;
        repeat (20) @(negedge clk);
        chk("ign_ndone", 64'(done_cnt8 - dc0), 64'd1);
        chk("ign_result", 64'({bus8.bout, bus8.diff}), 64'h07F);

        // reset during the 4th SHIFT cycle
        dc0 = done_cnt8;
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h20;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_busy", 64'(bus8.busy), 64'd0);
        chk("mrst_done", 64'(bus8.done), 64'd0);
        chk("mrst_diff", 64'(bus8.diff), 64'd0);
        chk("mrst_bout", 64'(bus8.bout), 64'd0);
        repeat (15) @(negedge clk);
        chk("mrst_nodone", 64'(done_cnt8 - dc0), 64'd0);
        op8(8'h20, 8'h10, r8, lat, bcyc);
        chk("r_20_10", 64'(r8), 64'h010);

        // start held for back-to-back operations
        cyc = 0; ndone = 0; unstable = 0;
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h0A; bus8.b = 8'h0B;
        while (ndone < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus8.done === 1'b1) begin
                t[ndone] = cyc;
                chk($sformatf("b2b_res%0d", ndone), 64'({bus8.bout, bus8.diff}), 64'h1FF);
                ndone++;
            end else if (ndone > 0 && {bus8.bout, bus8.diff} !== 9'h1FF) begin
                unstable++;
            end
        end
        bus8.start = 1'b0;
        chk("b2b_ndone", 64'(ndone), 64'd3);
        if (ndone == 3) begin
            chk("b2b_gap1", 64'(t[1] - t[0]), 64'd10);
            chk("b2b_gap2", 64'(t[2] - t[1]), 64'd10);
        end
        chk("b2b_stable", 64'(unstable), 64'd0);
        repeat (3) @(negedge clk);

        // random regression
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            op8(ra, rb, r8, lat, bcyc);
            chk($sformatf("rnd8 %02h-%02h", ra, rb), 64'(r8), 64'({(ra < rb), 8'(ra - rb)}));
        end
        for (int i = 0; i < 1000; i++) begin
            wa = 16'($urandom);
            wb = 16'($urandom);
            op16(wa, wb, r16);
            chk($sformatf("rnd16 %04h-%04h", wa, wb), 64'(r16), 64'({(wa < wb), 16'(wa - wb)}));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_serial_subtractor
